s2p_frame_buffer: RTL and testbench
===================================

Name: s2p_frame_buffer

Overview:
Parametrised ping-pong serial-to-parallel converter for the OFDM baseband chain. It collects a stream of signed samples into frames of runtime-selectable length (1..DEPTH) and presents each completed frame as a parallel vector to the IFFT stage. Both sides use valid/ready handshakes. Two frame banks allow one frame to fill while the previous frame waits for the consumer. Output lanes can optionally be emitted in bit-reversed order.

Parameters:
DATA_W, 32, sample width in bits (signed)
DEPTH, 8, maximum frame length; must be a power of two and at least 2
BIT_REV, 0, when 1 store sample k at lane bitrev(k) over log2(DEPTH) bits; when 0 store at lane k

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  DATA_W  signed input sample
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a sample this cycle
frame_len  input  $clog2(DEPTH)+1  frame length; sampled with the first sample of each frame
out_data  output  [DATA_W-1:0] x DEPTH  signed unpacked array of the parallel frame, lane 0 first
out_len  output  $clog2(DEPTH)+1  length of the frame currently presented
out_valid  output  1  out_data/out_len hold a complete frame
out_ready  input  1  consumer accepts the frame
frame_cnt  output  16  count of frames handed off; wraps modulo 2^16

Behaviour:
- Reset (rst=1 at a clock edge):
  - Both banks are marked empty and all bank storage is cleared to 0.
  - wr_cnt=0, wsel=0, rsel=0.
  - out_valid=0, out_len=0, frame_cnt=0, out_data all 0.
  - in_ready is forced to 0 while rst=1.
  - A partial frame in progress is discarded; a full bank that has not been handed off is discarded.
- Bank state: two banks, each with a full flag. wsel selects the write bank, rsel selects the read bank.
- Input side:
  - in_ready = !rst && !full[wsel]. It is 0 only when both banks are full.
  - An accept occurs when in_valid && in_ready.
  - On an accept with wr_cnt==0, latch the frame length len = frame_len.
    - frame_len==0 or frame_len>DEPTH is treated as DEPTH.
    - If BIT_REV=1, len is forced to DEPTH.
  - Sample number wr_cnt is written to its lane (k, or bitrev(k) if BIT_REV=1), then wr_cnt increments.
  - On the accept with wr_cnt==len-1:
    - set full[wsel] and record that bank's len;
    - toggle wsel and clear wr_cnt to 0;
    - zero the lanes len..DEPTH-1 of that bank so unused lanes read 0.
- Output side:
  - out_valid = full[rsel].
  - out_data and out_len are driven from bank rsel. They are stable while out_valid && !out_ready.
  - A handoff occurs when out_valid && out_ready. On a handoff: clear full[rsel], toggle rsel, increment frame_cnt.
- Latency: out_valid asserts the cycle after the last sample of a frame is accepted, provided the read bank is free.
- Throughput: one sample per clock is sustained indefinitely when the consumer handshakes at least once per frame. No sample is ever dropped; backpressure is applied only through in_ready.
- Simultaneous events:
  - Completing a fill and handing off the other bank in the same cycle are both honoured.
  - A handoff that frees the write bank raises in_ready on the next cycle, not combinationally.
- in_valid with in_ready=0 has no effect; the input is held by the producer.
- frame_len changes mid-frame are ignored until the next frame starts.

Test Plan:
- Reset then DEPTH=8, len=8, stream 5..12 with out_ready=1 -> out_valid 1 cycle after sample 12 accepted; out_data=[5,6,7,8,9,10,11,12]; frame_cnt=1.
- Continuous stream 1..32 with out_ready=1 -> 4 frames [1..8],[9..16],[17..24],[25..32]; in_ready never drops.
- out_ready=0, stream 1..20 -> in_ready falls after sample 16 accepted. Raising out_ready -> frames [1..8] then [9..16] handed off in order; samples 17..20 resume, no loss or duplication.
- frame_len=3, stream 7,8,9 -> out_data=[7,8,9,0,0,0,0,0], out_len=3. frame_len=0 -> treated as 8.
- BIT_REV=1, stream 0..7 -> out_data=[0,4,2,6,1,5,3,7].
- Assert rst after 5 samples of a frame and with one full bank -> next edge: out_valid=0, frame_cnt=0, in_ready=0 during rst. Next frame 20..27 is output intact.

Source files
------------

// File: rtl/s2p_frame_buffer.sv
// Ping-pong serial-to-parallel frame buffer: samples fill one bank while the
// other bank's completed frame is presented to the consumer.
module s2p_frame_buffer #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 8,
   parameter bit BIT_REV = 1'b0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic signed [DATA_W-1:0]        in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic        [$clog2(DEPTH):0]   frame_len,
   output logic signed [DATA_W-1:0]        out_data [DEPTH],
   output logic        [$clog2(DEPTH):0]   out_len,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic        [15:0]              frame_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic signed [DATA_W-1:0] bank [2][DEPTH];
   logic                     full [2];
   logic [LW-1:0]            bank_len [2];
   logic [LW-1:0]            cur_len;
   logic [AW-1:0]            wr_cnt;
   logic                     wsel;
   logic                     rsel;

   logic                     accept;
   logic                     handoff;
   logic [LW-1:0]            eff_len;
   logic [LW-1:0]            len_now;
   logic                     last;
   logic [AW-1:0]            lane;

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k);
      logic [AW-1:0] r;
      for (int b = 0; b < AW; b++) begin
         r[b] = k[AW-1-b];
      end
      return r;
   endfunction

   assign in_ready  = !rst && !full[wsel];
   assign accept    = in_valid && in_ready;
   assign out_valid = full[rsel];
   assign handoff   = out_valid && out_ready;
   assign out_len   = bank_len[rsel];

   // Out-of-range lengths collapse to a full frame; bit-reversed frames are always full.
   assign eff_len = (BIT_REV || frame_len == '0 || frame_len > DEPTH_L) ? DEPTH_L : frame_len;
   assign len_now = (wr_cnt == '0) ? eff_len : cur_len;
   assign last    = ({1'b0, wr_cnt} == len_now - 1'b1);
   assign lane    = BIT_REV ? bitrev(wr_cnt) : wr_cnt;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         out_data[i] = bank[rsel][i];
      end
   end

   // Fill and handoff always target different banks, so both may happen in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            full[b]     <= 1'b0;
            bank_len[b] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               bank[b][i] <= '0;
            end
         end
         cur_len   <= '0;
         wr_cnt    <= '0;
         wsel      <= 1'b0;
         rsel      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (accept) begin
            if (wr_cnt == '0) begin
               cur_len <= eff_len;
            end
            bank[wsel][lane] <= in_data;
            if (last) begin
               full[wsel]     <= 1'b1;
               bank_len[wsel] <= len_now;
               wsel           <= ~wsel;
               wr_cnt         <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  if (i >= int'(len_now)) begin
                     bank[wsel][i] <= '0;
                  end
               end
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end
         if (handoff) begin
            full[rsel] <= 1'b0;
            rsel       <= ~rsel;
            frame_cnt  <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_s2p_frame_buffer.sv
// Directed bench for s2p_frame_buffer: one DUT in natural lane order and one
// with bit-reversed lanes, checked against hand-computed frames.
module tb_s2p_frame_buffer;

   typedef logic [255:0] flat_t;

   logic               clk;
   logic               rst;
   logic signed [31:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic        [3:0]  frame_len;
   logic signed [31:0] out_data [8];
   logic        [3:0]  out_len;
   logic               out_valid;
   logic               out_ready;
   logic        [15:0] frame_cnt;

   logic signed [31:0] in_data2;
   logic               in_valid2;
   logic               in_ready2;
   logic        [3:0]  frame_len2;
   logic signed [31:0] out_data2 [8];
   logic        [3:0]  out_len2;
   logic               out_valid2;
   logic               out_ready2;
   logic        [15:0] frame_cnt2;

   int    pass_cnt;
   int    total_cnt;
   int    stall_cnt;
   flat_t cap_q[$];
   int    len_q[$];
   flat_t cap_tmp;

   s2p_frame_buffer #(.DATA_W(32), .DEPTH(8), .BIT_REV(1'b0)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .frame_len(frame_len),
      .out_data(out_data), .out_len(out_len), .out_valid(out_valid),
      .out_ready(out_ready), .frame_cnt(frame_cnt)
   );

   s2p_frame_buffer #(.DATA_W(32), .DEPTH(8), .BIT_REV(1'b1)) dut_rev (
      .clk(clk), .rst(rst),
      .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
      .frame_len(frame_len2),
      .out_data(out_data2), .out_len(out_len2), .out_valid(out_valid2),
      .out_ready(out_ready2), .frame_cnt(frame_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handoffs are captured mid-cycle; the transfer itself happens on the next rising edge.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         for (int i = 0; i < 8; i++) cap_tmp[i*32 +: 32] = out_data[i];
         cap_q.push_back(cap_tmp);
         len_q.push_back(int'(out_len));
      end
   end

   function automatic flat_t seq_frame(input int start, input int n);
      flat_t f;
      f = '0;
      for (int i = 0; i < n; i++) f[i*32 +: 32] = 32'(start + i);
      return f;
   endfunction

   function automatic flat_t pack_now();
      flat_t f;
      for (int i = 0; i < 8; i++) f[i*32 +: 32] = out_data[i];
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sample(input int v);
      int guard;
      guard = 0;
      while (!in_ready && guard < 200) begin
         tick();
         guard++;
         stall_cnt++;
      end
      if (guard >= 200) begin
         total_cnt++;
         $display("[TB] FAIL push_timeout: in_ready got 0 for 200 cycles, required 1 (sample %0d)", v);
      end
      in_valid = 1'b1;
      in_data  = 32'(v);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b required 0", in_ready);
      else pass_cnt++;
      total_cnt++;
      if (out_valid !== 1'b0 || out_len !== 4'd0 || frame_cnt !== 16'd0)
         $display("[TB] FAIL reset_outputs: got valid=%b len=%0d cnt=%0d required 0/0/0", out_valid, out_len, frame_cnt);
      else pass_cnt++;
      total_cnt++;
      if (pack_now() !== '0) $display("[TB] FAIL reset_data: got %h required 0", pack_now());
      else pass_cnt++;
      rst = 1'b0;
      tick();
      total_cnt++;
      if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready: got %b required 1", in_ready);
      else pass_cnt++;
   endtask

   task automatic test_single_frame();
      cap_q.delete();
      len_q.delete();
      out_ready = 1'b1;
      frame_len = 4'd8;
      for (int v = 5; v <= 12; v++) push_sample(v);
      total_cnt++;
      if (out_valid !== 1'b1 || out_len !== 4'd8)
         $display("[TB] FAIL single_latency: got valid=%b len=%0d required 1/8", out_valid, out_len);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (frame_cnt !== 16'd1 || out_valid !== 1'b0)
         $display("[TB] FAIL single_handoff: got cnt=%0d valid=%b required 1/0", frame_cnt, out_valid);
      else pass_cnt++;
      total_cnt++;
      if (cap_q.size() != 1 || cap_q[0] !== seq_frame(5, 8))
         $display("[TB] FAIL single_data: got %0d frames first=%h required 1 frame %h",
                  cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : flat_t'(0), seq_frame(5, 8));
      else pass_cnt++;
   endtask

   task automatic test_continuous();
      cap_q.delete();
      len_q.delete();
      stall_cnt = 0;
      for (int v = 1; v <= 32; v++) push_sample(v);
      repeat (3) tick();
      total_cnt++;
      if (stall_cnt != 0) $display("[TB] FAIL continuous_stall: got %0d stall cycles required 0", stall_cnt);
      else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 16'd5) $display("[TB] FAIL continuous_cnt: got %0d required 5", frame_cnt);
      else pass_cnt++;
      total_cnt++;
      if (cap_q.size() != 4) $display("[TB] FAIL continuous_frames: got %0d required 4", cap_q.size());
      else begin
         pass_cnt++;
         for (int f = 0; f < 4; f++) begin
            total_cnt++;
            if (cap_q[f] !== seq_frame(1 + 8*f, 8) || len_q[f] != 8)
               $display("[TB] FAIL continuous_frame%0d: got %h len %0d required %h len 8",
                        f, cap_q[f], len_q[f], seq_frame(1 + 8*f, 8));
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_back_pressure();
      cap_q.delete();
      len_q.delete();
      out_ready = 1'b0;
      stall_cnt = 0;
      for (int v = 1; v <= 16; v++) push_sample(v);
      total_cnt++;
      if (stall_cnt != 0 || in_ready !== 1'b0)
         $display("[TB] FAIL bp_fill: got stalls=%0d in_ready=%b required 0/0", stall_cnt, in_ready);
      else pass_cnt++;
      repeat (2) tick();
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || pack_now() !== seq_frame(1, 8))
         $display("[TB] FAIL bp_hold: got ready=%b valid=%b data=%h required 0/1/%h",
                  in_ready, out_valid, pack_now(), seq_frame(1, 8));
      else pass_cnt++;
      out_ready = 1'b1;
      for (int v = 17; v <= 24; v++) push_sample(v);
      repeat (3) tick();
      total_cnt++;
      if (stall_cnt == 0) $display("[TB] FAIL bp_release: got 0 stall cycles required at least 1");
      else pass_cnt++;
      total_cnt++;
      if (cap_q.size() != 3 || cap_q[0] !== seq_frame(1, 8) || cap_q[1] !== seq_frame(9, 8)
          || cap_q[2] !== seq_frame(17, 8))
         $display("[TB] FAIL bp_order: got %0d frames required 3 frames 1..8, 9..16, 17..24", cap_q.size());
      else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 16'd8) $display("[TB] FAIL bp_cnt: got %0d required 8", frame_cnt);
      else pass_cnt++;
   endtask

   task automatic test_short_frame();
      out_ready = 1'b0;
      frame_len = 4'd3;
      push_sample(7);
      push_sample(8);
      push_sample(9);
      total_cnt++;
      if (out_valid !== 1'b1 || out_len !== 4'd3 || pack_now() !== seq_frame(7, 3))
         $display("[TB] FAIL short_len3: got valid=%b len=%0d data=%h required 1/3/%h",
                  out_valid, out_len, pack_now(), seq_frame(7, 3));
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      frame_len = 4'd1;
      push_sample(50);
      total_cnt++;
      if (out_valid !== 1'b1 || out_len !== 4'd1 || pack_now() !== seq_frame(50, 1))
         $display("[TB] FAIL short_len1: got len=%0d data=%h required 1/%h", out_len, pack_now(), seq_frame(50, 1));
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      frame_len = 4'd0;
      push_sample(40);
      frame_len = 4'd3;
      for (int v = 41; v <= 47; v++) push_sample(v);
      total_cnt++;
      if (out_valid !== 1'b1 || out_len !== 4'd8 || pack_now() !== seq_frame(40, 8))
         $display("[TB] FAIL short_len0: got len=%0d data=%h required 8/%h", out_len, pack_now(), seq_frame(40, 8));
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      frame_len = 4'd9;
      for (int v = 60; v <= 67; v++) push_sample(v);
      total_cnt++;
      if (out_len !== 4'd8 || pack_now() !== seq_frame(60, 8))
         $display("[TB] FAIL short_len9: got len=%0d data=%h required 8/%h", out_len, pack_now(), seq_frame(60, 8));
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      frame_len = 4'd8;
   endtask

   task automatic test_bit_reverse();
      int    br [8];
      flat_t exp_f;
      flat_t got_f;
      br = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int i = 0; i < 8; i++) exp_f[i*32 +: 32] = 32'(br[i]);
      out_ready2 = 1'b0;
      frame_len2 = 4'd3;
      for (int v = 0; v < 8; v++) begin
         in_valid2 = 1'b1;
         in_data2  = 32'(v);
         tick();
      end
      in_valid2 = 1'b0;
      for (int i = 0; i < 8; i++) got_f[i*32 +: 32] = out_data2[i];
      total_cnt++;
      if (out_valid2 !== 1'b1 || out_len2 !== 4'd8 || got_f !== exp_f)
         $display("[TB] FAIL bitrev: got valid=%b len=%0d data=%h required 1/8/%h", out_valid2, out_len2, got_f, exp_f);
      else pass_cnt++;
   endtask

   task automatic test_reset_midframe();
      out_ready = 1'b0;
      frame_len = 4'd8;
      for (int v = 10; v <= 17; v++) push_sample(v);
      for (int v = 100; v <= 104; v++) push_sample(v);
      rst = 1'b1;
      tick();
      total_cnt++;
      if (out_valid !== 1'b0 || frame_cnt !== 16'd0 || in_ready !== 1'b0 || out_len !== 4'd0)
         $display("[TB] FAIL midreset: got valid=%b cnt=%0d ready=%b len=%0d required 0/0/0/0",
                  out_valid, frame_cnt, in_ready, out_len);
      else pass_cnt++;
      rst = 1'b0;
      tick();
      cap_q.delete();
      len_q.delete();
      out_ready = 1'b1;
      for (int v = 20; v <= 27; v++) push_sample(v);
      repeat (3) tick();
      total_cnt++;
      if (cap_q.size() != 1 || cap_q[0] !== seq_frame(20, 8) || frame_cnt !== 16'd1)
         $display("[TB] FAIL midreset_next: got %0d frames cnt=%0d required 1 frame %h cnt 1",
                  cap_q.size(), frame_cnt, seq_frame(20, 8));
      else pass_cnt++;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      pass_cnt   = 0;
      total_cnt  = 0;
      stall_cnt  = 0;
      rst        = 1'b1;
      in_data    = '0;
      in_valid   = 1'b0;
      frame_len  = 4'd8;
      out_ready  = 1'b0;
      in_data2   = '0;
      in_valid2  = 1'b0;
      frame_len2 = 4'd8;
      out_ready2 = 1'b0;
      test_reset();
      test_single_frame();
      test_continuous();
      test_back_pressure();
      test_short_frame();
      test_bit_reverse();
      test_reset_midframe();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
